// File: rtl/alu_arb_pkg.sv
// Shared types and helpers for the ALU arbiter: opcode widths, FSM states,
// the registered ALU operation bundle and the round-robin search.
package alu_arb_pkg;

    localparam int OP_WIDTH   = 4;
    localparam int MOVI_WIDTH = 2;
    localparam int ALU_DW     = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [OP_WIDTH-1:0]   op;
        logic [MOVI_WIDTH-1:0] movi;
        logic [ALU_DW-1:0]     a;
        logic [ALU_DW-1:0]     b;
        logic [ALU_DW-1:0]     mem;
        logic [ALU_DW-1:0]     imm;
    } alu_op_t;

    // First valid requester at or above ptr, wrapping at n (n <= 8).
    function automatic logic [2:0] rr_pick(input logic [7:0] vld,
                                           input logic [2:0] ptr,
                                           input logic [3:0] n);
        logic [2:0] win;
        logic       found;
        logic       hit;
        logic [3:0] idx;
        win   = 3'd0;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx   = {1'b0, ptr} + 4'(k);
            idx   = (idx >= n) ? (idx - n) : idx;
            hit   = !found && (4'(k) < n) && vld[idx[2:0]];
            win   = hit ? idx[2:0] : win;
            found = found | hit;
        end
        return win;
    endfunction

endpackage

// File: rtl/alu_arb_tag_fifo.sv
// In-order FIFO of requester tags for operations issued to the ALU and not
// yet answered. A push into a full FIFO is accepted when a pop happens alongside.
module alu_arb_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (count_r == CW'(0));
    assign full      = (count_r == CW'(DEPTH));
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);

    // Storage, pointers and occupancy; pointers wrap naturally as DEPTH is a power of 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU among NUM_REQ requesters; results are
// routed back to the issuing requester through an in-order tag FIFO.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = ALU_DW,
    parameter int MAX_OUTST  = 4
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic [NUM_REQ-1:0]                REQ_VLD,
    output logic [NUM_REQ-1:0]                REQ_RDY,
    input  logic [NUM_REQ*OP_WIDTH-1:0]       REQ_OP,
    input  logic [NUM_REQ*MOVI_WIDTH-1:0]     REQ_MOVI,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     REQ_REG_A,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     REQ_REG_B,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     REQ_MEM,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     REQ_IMM,
    output logic                              ALU_ACT,
    output logic [OP_WIDTH-1:0]               ALU_OP,
    output logic [MOVI_WIDTH-1:0]             ALU_MOVI,
    output logic [DATA_WIDTH-1:0]             ALU_REG_A,
    output logic [DATA_WIDTH-1:0]             ALU_REG_B,
    output logic [DATA_WIDTH-1:0]             ALU_MEM,
    output logic [DATA_WIDTH-1:0]             ALU_IMM,
    input  logic                              ALU_RDY,
    input  logic [DATA_WIDTH-1:0]             EX_ALU,
    input  logic                              EX_ALU_VLD,
    output logic [NUM_REQ-1:0]                RES_VLD,
    output logic [DATA_WIDTH-1:0]             RES_DATA,
    output logic [$clog2(MAX_OUTST+1)-1:0]    OUTST_CNT,
    output logic                              ERR_UNEXP
);

    localparam int TW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(MAX_OUTST + 1);

    arb_state_t    state_r;
    arb_state_t    state_s;
    logic          act_r;
    logic          act_s;
    alu_op_t       op_r;
    alu_op_t       sel_s;
    logic [TW-1:0] tag_r;
    logic [TW-1:0] head_tag_s;
    logic [2:0]    ptr_r;
    logic [2:0]    win_s;
    logic [2:0]    ptr_nxt_s;
    logic [7:0]    vld_pad_s;
    logic          any_vld_s;
    logic          can_grant_s;
    logic          grant_s;
    logic          push_s;
    logic          pop_s;
    logic          fifo_empty_s;
    logic          fifo_full_s;
    logic [CW-1:0] cnt_s;
    logic [CW:0]   cnt_after_s;
    logic          err_r;

    // Arbitration; a pop in the same cycle is deliberately not credited.
    always_comb begin
        vld_pad_s              = 8'd0;
        vld_pad_s[NUM_REQ-1:0] = REQ_VLD;
        win_s       = rr_pick(vld_pad_s, ptr_r, 4'(NUM_REQ));
        any_vld_s   = |REQ_VLD;
        push_s      = act_r & ALU_RDY;
        pop_s       = EX_ALU_VLD & ~fifo_empty_s;
        cnt_after_s = {1'b0, cnt_s} + (CW+1)'(push_s);
        can_grant_s = RST & ~fifo_full_s
                    & ((state_r == IDLE) | ((state_r == ISSUE) & ALU_RDY))
                    & (cnt_after_s < (CW+1)'(MAX_OUTST));
        grant_s     = can_grant_s & any_vld_s;
        ptr_nxt_s   = (win_s == 3'(NUM_REQ - 1)) ? 3'd0 : (win_s + 3'd1);
    end

    // Grant strobes and operand selection of the winning requester.
    always_comb begin
        REQ_RDY = '0;
        sel_s   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            REQ_RDY[i] = grant_s & (win_s == 3'(i));
            sel_s.op   = sel_s.op   | ({OP_WIDTH{win_s == 3'(i)}}   & REQ_OP[OP_WIDTH*i +: OP_WIDTH]);
            sel_s.movi = sel_s.movi | ({MOVI_WIDTH{win_s == 3'(i)}} & REQ_MOVI[MOVI_WIDTH*i +: MOVI_WIDTH]);
            sel_s.a    = sel_s.a    | ({DATA_WIDTH{win_s == 3'(i)}} & REQ_REG_A[DATA_WIDTH*i +: DATA_WIDTH]);
            sel_s.b    = sel_s.b    | ({DATA_WIDTH{win_s == 3'(i)}} & REQ_REG_B[DATA_WIDTH*i +: DATA_WIDTH]);
            sel_s.mem  = sel_s.mem  | ({DATA_WIDTH{win_s == 3'(i)}} & REQ_MEM[DATA_WIDTH*i +: DATA_WIDTH]);
            sel_s.imm  = sel_s.imm  | ({DATA_WIDTH{win_s == 3'(i)}} & REQ_IMM[DATA_WIDTH*i +: DATA_WIDTH]);
        end
    end

    // Issue FSM: ISSUE holds ALU_ACT until accepted, reloading back-to-back when possible.
    always_comb begin
        state_s = state_r;
        act_s   = act_r;
        case (state_r)
            IDLE: begin
                if (grant_s) begin
                    state_s = ISSUE;
                    act_s   = 1'b1;
                end else begin
                    state_s = IDLE;
                    act_s   = 1'b0;
                end
            end
            ISSUE: begin
                if (ALU_RDY && !grant_s) begin
                    state_s = IDLE;
                    act_s   = 1'b0;
                end else begin
                    state_s = ISSUE;
                    act_s   = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
                act_s   = 1'b0;
            end
        endcase
    end

    // State, ALU operation registers and round-robin pointer.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r <= IDLE;
            act_r   <= 1'b0;
            op_r    <= '0;
            tag_r   <= '0;
            ptr_r   <= 3'd0;
        end else begin
            state_r <= state_s;
            act_r   <= act_s;
            if (grant_s) begin
                op_r  <= sel_s;
                tag_r <= win_s[TW-1:0];
                ptr_r <= ptr_nxt_s;
            end else begin
                op_r  <= op_r;
                tag_r <= tag_r;
                ptr_r <= ptr_r;
            end
        end
    end

    // Sticky flag for a result that has no issued operation to belong to.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            err_r <= 1'b0;
        end else if (EX_ALU_VLD && fifo_empty_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    // Result demux onto the requester at the head of the tag FIFO.
    always_comb begin
        RES_VLD = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            RES_VLD[i] = pop_s & (head_tag_s == TW'(i));
        end
    end

    alu_arb_tag_fifo #(
        .WIDTH (TW),
        .DEPTH (MAX_OUTST)
    ) u_tag_fifo (
        .clk   (CLK),
        .rst_n (RST),
        .push  (push_s),
        .pop   (pop_s),
        .din   (tag_r),
        .dout  (head_tag_s),
        .empty (fifo_empty_s),
        .full  (fifo_full_s),
        .count (cnt_s)
    );

    assign ALU_ACT   = act_r;
    assign ALU_OP    = op_r.op;
    assign ALU_MOVI  = op_r.movi;
    assign ALU_REG_A = op_r.a;
    assign ALU_REG_B = op_r.b;
    assign ALU_MEM   = op_r.mem;
    assign ALU_IMM   = op_r.imm;
    assign RES_DATA  = EX_ALU;
    assign OUTST_CNT = cnt_s;
    assign ERR_UNEXP = err_r;

endmodule
